fifo_bridge_arb: RTL and testbench
==================================

FIFO_BRIDGE_ARB -- requirements
Module: fifo_bridge_arb

Interface
REQ-001 Parameter DATA_W, default 8, width of both data paths.
REQ-002 Parameter BURST_MAX, default 64, maximum words per burst; legal range 1..65535.
REQ-003 clk  in  1  single clock for all logic (FT2232H sync-FIFO CLKOUT domain).
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ft_rxf_n / ft_txe_n  in  1 each  host has data / host can accept data (active low).
REQ-006 ft_din  in  DATA_W  host-to-device data; ft_dout  out  DATA_W  device-to-host data; ft_dout_en  out  1  bus drive enable.
REQ-007 ft_rd_n / ft_wr_n / ft_oe_n  out  1 each  host read, write, output-enable strobes (active low).
REQ-008 fa_full  in  1  FIFO A almost-full: asserted while at most one free entry remains.
REQ-009 fa_wr  out  1  FIFO A write strobe; fa_data  out  DATA_W  FIFO A write data.
REQ-010 fb_empty  in  1  FIFO B empty (first-word-fall-through); fb_data  in  DATA_W  head word; fb_rd  out  1  FIFO B pop.

Function
REQ-011 States: IDLE, RX_OE, RX_BURST, TX_BURST, TURN; state, ft_rd_n, ft_oe_n, burst counter, last-served flag are registers.
REQ-012 IDLE: rx_rdy = !ft_rxf_n & !fa_full; tx_rdy = !ft_txe_n & !fb_empty; only rx_rdy -> RX_OE; only tx_rdy -> TX_BURST; both -> direction opposite to last-served; neither -> stay.
REQ-013 RX_OE: one cycle, ft_oe_n=0, ft_rd_n=1; then RX_BURST with ft_rd_n=0, ft_oe_n=0.
REQ-014 RX transfer at an edge when state RX_BURST & !ft_rd_n & !ft_rxf_n; fa_wr = that condition (combinational); fa_data = ft_din.
REQ-015 RX_BURST -> TURN (rd_n, oe_n high next cycle) on: ft_rxf_n high; fa_full high; or transfer with counter = BURST_MAX-1.
REQ-016 TX_BURST: ft_wr_n = !(TX_BURST & !fb_empty) (combinational); ft_dout = fb_data; ft_dout_en = TX_BURST.
REQ-017 TX transfer when TX_BURST & !fb_empty & !ft_txe_n; fb_rd = that condition; no pop without host acceptance.
REQ-018 TX_BURST -> TURN on: fb_empty high; ft_txe_n high; or transfer with counter = BURST_MAX-1.
REQ-019 TURN: exactly one cycle, all strobes inactive, ft_dout_en=0; then IDLE; last-served updated on entering TURN.
REQ-020 Burst counter cleared on burst entry, increments per transfer, width ceil(log2(BURST_MAX+1)); BURST_MAX=1 gives single-word bursts.
REQ-021 fa_full rising during a transfer edge: that word is written (reserved entry); no word lost or duplicated.
REQ-022 ft_rd_n and ft_wr_n never both low; ft_oe_n low only in RX_OE/RX_BURST.

Reset
REQ-023 rst_n low: state IDLE, ft_rd_n=ft_wr_n=ft_oe_n=1, fa_wr=fb_rd=0, ft_dout_en=0, counter 0, last-served=TX (RX wins first tie), immediately and asynchronously.
REQ-024 Reset mid-burst aborts the burst; in-flight word at the reset edge is not transferred; release resumes from IDLE on next edge.

Configuration
REQ-025 Macro FIFO_BRIDGE_STATS_EN defined: adds outputs rx_count, tx_count (32 bits each), incremented per RX/TX transfer, wrap at 2^32, cleared by reset.
REQ-026 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-027 Host supplies 10 words, FIFO A space, BURST_MAX=64 -> one RX_OE cycle, 10 fa_wr pulses with matching data, TURN, IDLE.
REQ-028 FIFO B holds 100 words, ft_txe_n low, BURST_MAX=64 -> bursts of 64 and 36 words separated by one TURN cycle, 100 fb_rd pulses, data in order.
REQ-029 rx_rdy and tx_rdy both held true from reset -> RX, TX, RX, TX burst order.
REQ-030 fa_full raised after 5th transfer edge -> exactly 6 words written, ft_rd_n high next cycle, no further fa_wr until fa_full low.
REQ-031 ft_txe_n high for 3 cycles mid-TX-burst -> no fb_rd during those cycles, burst ends via TURN, resumes with next word unchanged.
REQ-032 rst_n low mid-RX-burst -> strobes inactive same cycle, rx_count (STATS_EN) = 0, clean restart after release.

Source files
------------

// File: rtl/fifo_bridge_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_bridge_arb
// Brief    : FT2232H sync-FIFO bridge arbitrating host RX into FIFO A and
//            FIFO B into host TX; optional counters via FIFO_BRIDGE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_bridge_arb #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ft_rxf_n,
    input  logic              ft_txe_n,
    input  logic [DATA_W-1:0] ft_din,
    output logic [DATA_W-1:0] ft_dout,
    output logic              ft_dout_en,
    output logic              ft_rd_n,
    output logic              ft_wr_n,
    output logic              ft_oe_n,
    input  logic              fa_full,
    output logic              fa_wr,
    output logic [DATA_W-1:0] fa_data,
    input  logic              fb_empty,
    input  logic [DATA_W-1:0] fb_data,
    output logic              fb_rd
`ifdef FIFO_BRIDGE_STATS_EN
    ,
    output logic [31:0]       rx_count,
    output logic [31:0]       tx_count
`endif
);

    localparam int c_cnt_w = $clog2(BURST_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BURST_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RX_OE    = 3'd1,
        S_RX_BURST = 3'd2,
        S_TX_BURST = 3'd3,
        S_TURN     = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_rd_n, w_rd_n_nxt;
    logic                 r_oe_n, w_oe_n_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_last_tx, w_last_tx_nxt;

    logic w_rx_rdy, w_tx_rdy, w_rx_xfer, w_tx_xfer, w_cnt_last;

    assign w_rx_rdy   = !ft_rxf_n && !fa_full;
    assign w_tx_rdy   = !ft_txe_n && !fb_empty;
    // fa_full is deliberately not in the RX transfer term: the word already
    // on the bus when almost-full rises lands in the reserved entry.
    assign w_rx_xfer  = (r_state == S_RX_BURST) && !r_rd_n && !ft_rxf_n;
    assign w_tx_xfer  = (r_state == S_TX_BURST) && !fb_empty && !ft_txe_n;
    assign w_cnt_last = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_cnt     <= '0;
            r_last_tx <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_n    <= w_rd_n_nxt;
            r_oe_n    <= w_oe_n_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last_tx <= w_last_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_n_nxt    = r_rd_n;
        w_oe_n_nxt    = r_oe_n;
        w_cnt_nxt     = r_cnt;
        w_last_tx_nxt = r_last_tx;
        case (r_state)
            S_IDLE: begin
                if (w_rx_rdy && (!w_tx_rdy || r_last_tx)) begin
                    w_state_nxt = S_RX_OE;
                    w_oe_n_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (w_tx_rdy) begin
                    w_state_nxt = S_TX_BURST;
                    w_cnt_nxt   = '0;
                end
            end
            S_RX_OE: begin
                w_state_nxt = S_RX_BURST;
                w_rd_n_nxt  = 1'b0;
            end
            S_RX_BURST: begin
                if (w_rx_xfer)
                    w_cnt_nxt = r_cnt + 1'b1;
                if (ft_rxf_n || fa_full || (w_rx_xfer && w_cnt_last)) begin
                    w_state_nxt   = S_TURN;
                    w_rd_n_nxt    = 1'b1;
                    w_oe_n_nxt    = 1'b1;
                    w_last_tx_nxt = 1'b0;
                end
            end
            S_TX_BURST: begin
                if (w_tx_xfer)
                    w_cnt_nxt = r_cnt + 1'b1;
                if (fb_empty || ft_txe_n || (w_tx_xfer && w_cnt_last)) begin
                    w_state_nxt   = S_TURN;
                    w_last_tx_nxt = 1'b1;
                end
            end
            S_TURN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rd_n_nxt  = 1'b1;
                w_oe_n_nxt  = 1'b1;
            end
        endcase
    end

    assign ft_rd_n    = r_rd_n;
    assign ft_oe_n    = r_oe_n;
    assign ft_wr_n    = !((r_state == S_TX_BURST) && !fb_empty);
    assign ft_dout    = fb_data;
    assign ft_dout_en = (r_state == S_TX_BURST);
    assign fa_wr      = w_rx_xfer;
    assign fa_data    = ft_din;
    assign fb_rd      = w_tx_xfer;

`ifdef FIFO_BRIDGE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (w_rx_xfer)
                rx_count <= rx_count + 32'd1;
            if (w_tx_xfer)
                tx_count <= tx_count + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_bridge_arb.sv
`default_nettype none
// Directed self-checking bench for fifo_bridge_arb (BURST_MAX = 64).
module tb_fifo_bridge_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ft_rxf_n, ft_txe_n, fa_full, fb_empty;
    logic [7:0] ft_din, fb_data;
    logic [7:0] ft_dout, fa_data;
    logic       ft_dout_en, ft_rd_n, ft_wr_n, ft_oe_n, fa_wr, fb_rd;
`ifdef FIFO_BRIDGE_STATS_EN
    logic [31:0] rx_count, tx_count;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fifo_bridge_arb #(.DATA_W(8), .BURST_MAX(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ft_rxf_n   (ft_rxf_n),
        .ft_txe_n   (ft_txe_n),
        .ft_din     (ft_din),
        .ft_dout    (ft_dout),
        .ft_dout_en (ft_dout_en),
        .ft_rd_n    (ft_rd_n),
        .ft_wr_n    (ft_wr_n),
        .ft_oe_n    (ft_oe_n),
        .fa_full    (fa_full),
        .fa_wr      (fa_wr),
        .fa_data    (fa_data),
        .fb_empty   (fb_empty),
        .fb_data    (fb_data),
        .fb_rd      (fb_rd)
`ifdef FIFO_BRIDGE_STATS_EN
        ,
        .rx_count   (rx_count),
        .tx_count   (tx_count)
`endif
    );

    task automatic idle_inputs();
        ft_rxf_n = 1'b1;
        ft_txe_n = 1'b1;
        fa_full  = 1'b0;
        fb_empty = 1'b1;
        ft_din   = 8'h00;
        fb_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ft_rxf_n = 1'b0; ft_txe_n = 1'b0; fa_full = 1'b0; fb_empty = 1'b0;
        ft_din = 8'h11; fb_data = 8'h22;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (ft_rd_n !== 1'b1) begin failed++; $display("FAIL reset_rd_n: got %b expected 1", ft_rd_n); end
        tests++; if (ft_wr_n !== 1'b1) begin failed++; $display("FAIL reset_wr_n: got %b expected 1", ft_wr_n); end
        tests++; if (ft_oe_n !== 1'b1) begin failed++; $display("FAIL reset_oe_n: got %b expected 1", ft_oe_n); end
        tests++; if (fa_wr !== 1'b0) begin failed++; $display("FAIL reset_fa_wr: got %b expected 0", fa_wr); end
        tests++; if (fb_rd !== 1'b0) begin failed++; $display("FAIL reset_fb_rd: got %b expected 0", fb_rd); end
        tests++; if (ft_dout_en !== 1'b0) begin failed++; $display("FAIL reset_dout_en: got %b expected 0", ft_dout_en); end
`ifdef FIFO_BRIDGE_STATS_EN
        tests++; if (rx_count !== 32'd0) begin failed++; $display("FAIL reset_rx_count: got %0d expected 0", rx_count); end
        tests++; if (tx_count !== 32'd0) begin failed++; $display("FAIL reset_tx_count: got %0d expected 0", tx_count); end
`endif
        do_reset();
    endtask

    // Host offers 10 words; expect one OE-only cycle then 10 writes in order.
    task automatic test_rx_burst();
        int sent = 0, oe_only = 0, bad = 0;
        do_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            ft_rxf_n = (sent >= 10);
            ft_din   = 8'(8'h10 + sent);
            #1;
            if (!ft_oe_n && ft_rd_n) oe_only++;
            if (!ft_rd_n && !ft_wr_n) bad++;
            if (fa_wr) begin
                tests++;
                if (fa_data !== 8'(8'h10 + sent)) begin
                    failed++; $display("FAIL rx_data: got %h expected %h", fa_data, 8'(8'h10 + sent));
                end
                sent++;
            end
        end
        tests++; if (sent != 10) begin failed++; $display("FAIL rx_words: got %0d expected 10", sent); end
        tests++; if (oe_only != 1) begin failed++; $display("FAIL rx_oe_cycles: got %0d expected 1", oe_only); end
        tests++; if (ft_rd_n !== 1'b1 || ft_oe_n !== 1'b1) begin
            failed++; $display("FAIL rx_idle_strobes: got rd_n=%b oe_n=%b expected 1 1", ft_rd_n, ft_oe_n);
        end
        tests++; if (bad != 0) begin failed++; $display("FAIL rx_strobe_overlap: got %0d expected 0", bad); end
    endtask

    // FIFO B holds 100 words; expect bursts of 64 and 36.
    task automatic test_tx_burst();
        int popped = 0, cur = 0, nb = 0, bad = 0;
        int bursts[4];
        logic prev_en = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 160; cyc++) begin
            @(negedge clk);
            fb_empty = (popped >= 100);
            fb_data  = 8'(8'h40 + popped);
            ft_txe_n = 1'b0;
            #1;
            if ((!ft_rd_n && !ft_wr_n) || !ft_oe_n) bad++;
            if (fb_rd) begin
                tests++;
                if (ft_dout !== 8'(8'h40 + popped) || ft_wr_n !== 1'b0 || ft_dout_en !== 1'b1) begin
                    failed++; $display("FAIL tx_data: got %h wr_n=%b en=%b expected %h 0 1",
                                       ft_dout, ft_wr_n, ft_dout_en, 8'(8'h40 + popped));
                end
                popped++;
                cur++;
            end
            if (prev_en && !ft_dout_en && nb < 4) begin
                bursts[nb] = cur;
                nb++;
                cur = 0;
            end
            prev_en = ft_dout_en;
        end
        tests++; if (popped != 100) begin failed++; $display("FAIL tx_words: got %0d expected 100", popped); end
        tests++; if (nb != 2) begin failed++; $display("FAIL tx_burst_count: got %0d expected 2", nb); end
        tests++; if (nb < 1 || bursts[0] != 64) begin failed++; $display("FAIL tx_burst0_len: got %0d expected 64", bursts[0]); end
        tests++; if (nb < 2 || bursts[1] != 36) begin failed++; $display("FAIL tx_burst1_len: got %0d expected 36", bursts[1]); end
        tests++; if (bad != 0) begin failed++; $display("FAIL tx_strobe_rules: got %0d expected 0", bad); end
        idle_inputs();
    endtask

    // Both sides ready from reset: expect RX, TX, RX, TX.
    task automatic test_arb_order();
        int ord[4];
        int nev = 0, rx_first = 0;
        logic prev_oe = 1'b1, prev_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        ft_rxf_n = 1'b0; ft_txe_n = 1'b0; fa_full = 1'b0; fb_empty = 1'b0;
        ft_din = 8'h33; fb_data = 8'h5A;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 400 && nev < 4; cyc++) begin
            @(negedge clk);
            #1;
            if (fa_wr && nev < 2) rx_first++;
            if (prev_oe && !ft_oe_n) begin ord[nev] = 1; nev++; end
            else if (!prev_en && ft_dout_en) begin ord[nev] = 2; nev++; end
            prev_oe = ft_oe_n;
            prev_en = ft_dout_en;
        end
        tests++; if (nev != 4) begin failed++; $display("FAIL arb_events: got %0d expected 4", nev); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i < nev && ord[i] != ((i % 2 == 0) ? 1 : 2)) begin
                failed++; $display("FAIL arb_order[%0d]: got %0d expected %0d (1=RX 2=TX)", i, ord[i], (i % 2 == 0) ? 1 : 2);
            end
        end
        tests++; if (rx_first != 64) begin failed++; $display("FAIL arb_rx_burst_len: got %0d expected 64", rx_first); end
        idle_inputs();
        do_reset();
    endtask

    // fa_full rises after the 5th transfer: 6 words total, then stall.
    task automatic test_fa_full();
        int sent = 0, full_cyc = 0, bad = 0, at_drop = -1;
        do_reset();
        ft_rxf_n = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            fa_full = (sent >= 5) && (full_cyc < 6);
            ft_din  = 8'(8'h80 + sent);
            #1;
            if (fa_full) begin
                full_cyc++;
                if (full_cyc == 1) begin
                    tests++; if (fa_wr !== 1'b1) begin failed++; $display("FAIL full_reserved_wr: got %b expected 1", fa_wr); end
                end else begin
                    if (fa_wr) bad++;
                    if (full_cyc == 2) begin
                        tests++; if (ft_rd_n !== 1'b1) begin failed++; $display("FAIL full_rd_n_next: got %b expected 1", ft_rd_n); end
                    end
                end
            end else if (full_cyc == 6 && at_drop < 0) begin
                at_drop = sent;
            end
            if (fa_wr) begin
                tests++;
                if (fa_data !== 8'(8'h80 + sent)) begin
                    failed++; $display("FAIL full_data: got %h expected %h", fa_data, 8'(8'h80 + sent));
                end
                sent++;
            end
        end
        tests++; if (bad != 0) begin failed++; $display("FAIL full_extra_wr: got %0d expected 0", bad); end
        tests++; if (at_drop != 6) begin failed++; $display("FAIL full_words: got %0d expected 6", at_drop); end
        tests++; if (sent <= 6) begin failed++; $display("FAIL full_resume: got %0d words expected more than 6", sent); end
        idle_inputs();
    endtask

    // Host stalls for 3 cycles mid-TX: no pops, TURN, resume in order.
    task automatic test_txe_pause();
        int popped = 0, pcyc = 0, bad = 0;
        do_reset();
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            fb_empty = (popped >= 20);
            fb_data  = 8'(8'hC0 + popped);
            ft_txe_n = (popped >= 5) && (pcyc < 3);
            if (ft_txe_n) pcyc++;
            #1;
            if (ft_txe_n) begin
                if (fb_rd) bad++;
                if (pcyc == 2) begin
                    tests++; if (ft_dout_en !== 1'b0) begin failed++; $display("FAIL pause_turn_en: got %b expected 0", ft_dout_en); end
                end
            end
            if (fb_rd) begin
                tests++;
                if (ft_dout !== 8'(8'hC0 + popped)) begin
                    failed++; $display("FAIL pause_data: got %h expected %h", ft_dout, 8'(8'hC0 + popped));
                end
                popped++;
            end
        end
        tests++; if (bad != 0) begin failed++; $display("FAIL pause_pop: got %0d expected 0", bad); end
        tests++; if (popped != 20) begin failed++; $display("FAIL pause_words: got %0d expected 20", popped); end
        idle_inputs();
    endtask

    // Reset asserted mid-RX burst, then a clean restart.
    task automatic test_reset_mid();
        int sent = 0, oe_only = 0;
        do_reset();
        ft_rxf_n = 1'b0;
        for (int cyc = 0; cyc < 20 && sent < 3; cyc++) begin
            @(negedge clk);
            ft_din = 8'(8'h20 + sent);
            #1;
            if (fa_wr) sent++;
        end
        tests++; if (sent != 3) begin failed++; $display("FAIL rst_mid_setup: got %0d expected 3", sent); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (ft_rd_n !== 1'b1 || ft_oe_n !== 1'b1 || ft_wr_n !== 1'b1) begin
            failed++; $display("FAIL rst_mid_strobes: got rd_n=%b oe_n=%b wr_n=%b expected 1 1 1", ft_rd_n, ft_oe_n, ft_wr_n);
        end
        tests++; if (fa_wr !== 1'b0 || fb_rd !== 1'b0 || ft_dout_en !== 1'b0) begin
            failed++; $display("FAIL rst_mid_pulses: got fa_wr=%b fb_rd=%b en=%b expected 0 0 0", fa_wr, fb_rd, ft_dout_en);
        end
`ifdef FIFO_BRIDGE_STATS_EN
        tests++; if (rx_count !== 32'd0) begin failed++; $display("FAIL rst_mid_rx_count: got %0d expected 0", rx_count); end
`endif
        @(negedge clk);
        ft_rxf_n = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests++; if (ft_rd_n !== 1'b1 || ft_oe_n !== 1'b1) begin
            failed++; $display("FAIL rst_mid_idle: got rd_n=%b oe_n=%b expected 1 1", ft_rd_n, ft_oe_n);
        end
        sent = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            ft_rxf_n = (sent >= 4);
            ft_din   = 8'(8'h60 + sent);
            #1;
            if (!ft_oe_n && ft_rd_n) oe_only++;
            if (fa_wr) begin
                tests++;
                if (fa_data !== 8'(8'h60 + sent)) begin
                    failed++; $display("FAIL rst_mid_data: got %h expected %h", fa_data, 8'(8'h60 + sent));
                end
                sent++;
            end
        end
        tests++; if (sent != 4 || oe_only != 1) begin
            failed++; $display("FAIL rst_mid_restart: got words=%0d oe=%0d expected 4 1", sent, oe_only);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rx_burst();
        test_tx_burst();
        test_arb_order();
        test_fa_full();
        test_txe_pause();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
